cache_nway_datapath: RTL

Parametrised N-way set-associative, write-back, write-allocate LC-3b cache with an integrated controller FSM and tree pseudo-LRU replacement. It sits between the CPU memory port (16-bit word interface) and physical memory (128-bit line interface). It generalises the fixed 2-way datapath to a configurable way count and set count, and adds:
- byte-enable writes;
- invalid-way-first victim selection;
- saturating hit/miss counters.

---
 rtl/cache_nway_datapath.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cache_nway_datapath.sv
// N-way set-associative write-back/write-allocate cache with tree pseudo-LRU,
// byte-enable writes, invalid-first victim choice and saturating hit/miss counters.
module cache_nway_datapath #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SETS  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_byte_enable,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_rdata,
  output logic              mem_resp,
  output logic [15:0]       pmem_address,
  input  logic [127:0]      pmem_rdata,
  output logic [127:0]      pmem_wdata,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 12 - IDX_W;
  localparam int unsigned WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  state_t state, state_next;

  logic [SETS-1:0][WAYS-1:0] valid;
  logic [SETS-1:0][WAYS-1:0] dirty;
  logic [SETS-1:0][WAYS-2:0] plru;
  logic [TAG_W-1:0]          tags [SETS][WAYS];
  logic [127:0]              data [SETS][WAYS];
  logic [WAY_W-1:0]          victim_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       word;
  logic             req;
  logic             unused_addr_bit;

  assign idx             = mem_address[4+IDX_W-1:4];
  assign tag             = mem_address[15:4+IDX_W];
  assign word            = mem_address[3:1];
  assign req             = mem_read | mem_write;
  assign unused_addr_bit = mem_address[0];

  logic             hit;
  logic [WAY_W-1:0] hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid[idx][w[WAY_W-1:0]] && (tags[idx][w[WAY_W-1:0]] == tag)) begin
        hit     = 1'b1;
        hit_way = w[WAY_W-1:0];
      end
    end
  end

  // Tree nodes are heap-ordered: node n has children 2n+1 (bit=0) and 2n+2 (bit=1).
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] plru_way;
  logic [WAY_W-1:0] victim;

  always_comb begin
    int unsigned n;
    logic        b;
    inv_found = 1'b0;
    inv_way   = '0;
    plru_way  = '0;
    n         = 0;
    b         = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!valid[idx][w[WAY_W-1:0]] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = w[WAY_W-1:0];
      end
    end
    for (int unsigned l = 0; l < WAY_W; l++) begin
      b        = plru[idx][n[WAY_W-1:0]];
      plru_way = (plru_way << 1) | WAY_W'(b);
      n        = 2 * n + 1 + 32'(b);
    end
    victim = inv_found ? inv_way : plru_way;
  end

  logic [WAYS-2:0] plru_upd;

  always_comb begin
    int unsigned      n;
    logic [WAY_W-1:0] hw;
    plru_upd = plru[idx];
    n        = 0;
    hw       = hit_way;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      plru_upd[n[WAY_W-1:0]] = ~hw[WAY_W-1];
      n  = 2 * n + 1 + 32'(hw[WAY_W-1]);
      hw = hw << 1;
    end
  end

  logic [7:0][15:0] hit_line;
  logic [7:0][15:0] merged;

  always_comb begin
    hit_line = data[idx][hit_way];
    merged   = hit_line;
    if (mem_byte_enable[0]) merged[word][7:0]  = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged[word][15:8] = mem_wdata[15:8];
  end

  assign mem_rdata  = hit_line[word];
  assign pmem_wdata = data[idx][victim_q];

  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {tag, idx, 4'b0000};
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) mem_resp = 1'b1;
          else if (valid[idx][victim] && dirty[idx][victim]) state_next = WRITEBACK;
          else state_next = ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tags[idx][victim_q], idx, 4'b0000};
        if (pmem_resp) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      victim_q   <= '0;
      valid      <= '0;
      dirty      <= '0;
      plru       <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req) begin
        if (hit) begin
          plru[idx] <= plru_upd;
          if (hit_count != '1) hit_count <= hit_count + 1'b1;
          if (mem_write) dirty[idx][hit_way] <= 1'b1;
        end else begin
          victim_q <= victim;
          if (miss_count != '1) miss_count <= miss_count + 1'b1;
        end
      end
      if (state == ALLOCATE && pmem_resp) begin
        valid[idx][victim_q] <= 1'b1;
        dirty[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Line storage has no reset; validity alone decides whether contents are used.
  always_ff @(posedge clk) begin
    if (state == IDLE && req && hit && mem_write) data[idx][hit_way] <= merged;
    if (state == ALLOCATE && pmem_resp) begin
      data[idx][victim_q] <= pmem_rdata;
      tags[idx][victim_q] <= tag;
    end
  end

endmodule
